// File: rtl/sgmii_link_ctrl.sv
// SGMII link bring-up sequencer: PHY reset, settle, autonegotiation restart/retry,
// and PCS speed selection from the synchronized PCS/PMA status vector.
module sgmii_link_ctrl #(
    parameter int unsigned RESET_CYCLES  = 125000,
    parameter int unsigned SETTLE_CYCLES = 625000,
    parameter int unsigned AN_TIMEOUT    = 125000000,
    parameter int unsigned MAX_RETRIES   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] status_vector,
    output logic        phy_reset_n,
    output logic        an_restart,
    output logic        speed_is_10_100,
    output logic        speed_is_100,
    output logic        link_up,
    output logic [7:0]  retry_count,
    output logic [2:0]  state
);

    localparam int unsigned MAX_RS  = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_ALL = (MAX_RS > AN_TIMEOUT) ? MAX_RS : AN_TIMEOUT;
    localparam int          CW      = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] RESET_LAST  = CW'(RESET_CYCLES - 32'd1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 32'd1);
    localparam logic [CW-1:0] AN_LAST     = CW'(AN_TIMEOUT - 32'd1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(32'd1);
    localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RESET    = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_AN_START = 3'd3,
        ST_AN_WAIT  = 3'd4,
        ST_LINK     = 3'd5
    } state_t;

    // Maps the PCS speed code to {speed_is_10_100, speed_is_100}; reserved 11 falls back to 1G.
    function automatic logic [1:0] speed_decode(input logic [1:0] spd);
        logic [1:0] ctl;
        case (spd)
            2'b00:   ctl = 2'b10;
            2'b01:   ctl = 2'b11;
            2'b10:   ctl = 2'b00;
            2'b11:   ctl = 2'b00;
            default: ctl = 2'b00;
        endcase
        return ctl;
    endfunction

    state_t        state_r;
    state_t        next_state_s;
    logic [CW-1:0] cnt_r;
    logic [7:0]    retry_r;
    logic [7:0]    retry_upd_s;
    logic [7:0]    retry_inc_s;
    logic          retry_hit_s;
    logic          entry_s;
    logic [3:0]    sync1_r;
    logic [3:0]    sync2_r;
    logic          link_ok_s;
    logic [1:0]    speed_s;
    logic          phy_reset_n_r;
    logic          an_restart_r;
    logic          link_up_r;
    logic          speed_is_10_100_r;
    logic          speed_is_100_r;
    logic          unused_status_s;

    assign unused_status_s = ^{status_vector[15:12], status_vector[9:2]};

    // Two-flop synchronizer for {speed[1:0], link_sync, link_status}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= {status_vector[11:10], status_vector[1:0]};
            sync2_r <= sync1_r;
        end
    end

    assign link_ok_s   = sync2_r[0] & sync2_r[1];
    assign speed_s     = sync2_r[3:2];
    assign retry_inc_s = (retry_r == 8'd255) ? 8'd255 : (retry_r + 8'd1);
    assign retry_hit_s = ({24'd0, retry_inc_s} == MAX_RETRIES);
    assign entry_s     = (next_state_s != state_r);

    // Next-state and retry bookkeeping; enable low overrides everything.
    always_comb begin
        next_state_s = state_r;
        retry_upd_s  = retry_r;
        if (!enable) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: next_state_s = ST_RESET;
                ST_RESET: begin
                    if (cnt_r == RESET_LAST) next_state_s = ST_SETTLE;
                    else                     next_state_s = ST_RESET;
                end
                ST_SETTLE: begin
                    if (cnt_r == SETTLE_LAST) next_state_s = ST_AN_START;
                    else                      next_state_s = ST_SETTLE;
                end
                ST_AN_START: next_state_s = ST_AN_WAIT;
                ST_AN_WAIT: begin
                    // A qualified link wins over a timeout landing on the same cycle.
                    if (link_ok_s) begin
                        next_state_s = ST_LINK;
                    end else if (cnt_r == AN_LAST) begin
                        retry_upd_s = retry_inc_s;
                        if (retry_hit_s) next_state_s = ST_RESET;
                        else             next_state_s = ST_AN_START;
                    end else begin
                        next_state_s = ST_AN_WAIT;
                    end
                end
                ST_LINK: begin
                    if (link_ok_s) next_state_s = ST_LINK;
                    else           next_state_s = ST_AN_START;
                end
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // State, cycle counter and retry counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            retry_r <= 8'd0;
        end else begin
            state_r <= next_state_s;
            if (entry_s)               cnt_r <= {CW{1'b0}};
            else if (cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_ONE;
            else                       cnt_r <= cnt_r;
            if (entry_s && ((next_state_s == ST_RESET) || (next_state_s == ST_LINK))) retry_r <= 8'd0;
            else                                                                      retry_r <= retry_upd_s;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phy_reset_n_r     <= 1'b0;
            an_restart_r      <= 1'b0;
            link_up_r         <= 1'b0;
            speed_is_10_100_r <= 1'b0;
            speed_is_100_r    <= 1'b0;
        end else begin
            phy_reset_n_r <= (next_state_s != ST_IDLE) && (next_state_s != ST_RESET);
            an_restart_r  <= (next_state_s == ST_AN_START);
            link_up_r     <= (next_state_s == ST_LINK);
            if (next_state_s == ST_LINK) begin
                {speed_is_10_100_r, speed_is_100_r} <= speed_decode(speed_s);
            end else begin
                speed_is_10_100_r <= speed_is_10_100_r;
                speed_is_100_r    <= speed_is_100_r;
            end
        end
    end

    assign phy_reset_n     = phy_reset_n_r;
    assign an_restart      = an_restart_r;
    assign link_up         = link_up_r;
    assign speed_is_10_100 = speed_is_10_100_r;
    assign speed_is_100    = speed_is_100_r;
    assign retry_count     = retry_r;
    assign state           = state_r;

endmodule
